// File: rtl/apb_rr_sequencer.sv
// apb_rr_sequencer: round-robin sharing of one APB master among NREQ requesters.
// Build option: define APB_TIMEOUT_EN to bound ACCESS waits at TIMEOUT_CYCLES.
module apb_rr_sequencer #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                PCLK,
  input  logic                PRESETN,
  input  logic [NREQ-1:0]     REQ,
  input  logic [NREQ-1:0]     REQ_WRITE,
  input  logic [32*NREQ-1:0]  REQ_ADDR,
  input  logic [32*NREQ-1:0]  REQ_WDATA,
  output logic [NREQ-1:0]     DONE,
  output logic [31:0]         RSP_RDATA,
  output logic                RSP_ERR,
  output logic                BUSY,
  output logic [31:0]         PADDR,
  output logic [15:0]         PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [31:0]         PWDATA,
  input  logic [31:0]         PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  localparam int IW = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [31:0]     paddr_q, paddr_d;
  logic [31:0]     pwdata_q, pwdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            pwrite_q, pwrite_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] elig;
  logic [IW-1:0]   pick;
  logic            found;
  int              idx;
  logic            tmo;
  logic            fin;

`ifdef APB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign tmo = (state_q == S_ACCESS) && !PREADY
            && (cnt_q == 16'(TIMEOUT_CYCLES));

  // wait counter: cleared in SETUP, counts PREADY-low ACCESS cycles
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_SETUP)
      cnt_d = '0;
    else if (state_q == S_ACCESS && !PREADY)
      cnt_d = cnt_q + 16'd1;
  end

  // wait counter register
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  assign fin = (state_q == S_ACCESS) && (PREADY || tmo);

  // round-robin pick: first eligible after the last grant, with wrap
  always_comb begin
    elig  = REQ & ~done_q;
    pick  = last_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  // next-state and datapath updates for the APB phase machine
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    done_d   = '0;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d  = S_SETUP;
          last_d   = pick;
          paddr_d  = REQ_ADDR[32*pick +: 32];
          pwdata_d = REQ_WDATA[32*pick +: 32];
          pwrite_d = REQ_WRITE[pick];
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (fin) begin
          state_d        = S_IDLE;
          done_d[last_q] = 1'b1;
          err_d          = tmo | PSLVERR;
          if (!pwrite_q)
            rdata_d = tmo ? 32'h0 : PRDATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q  <= S_IDLE;
      last_q   <= IW'(NREQ - 1);
      done_q   <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      done_q   <= done_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign BUSY      = (state_q != S_IDLE);
  assign PENABLE   = (state_q == S_ACCESS);
  assign PSEL      = BUSY ? (16'd1 << paddr_q[27:24]) : 16'd0;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign DONE      = done_q;
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = err_q;

endmodule
